// File: rtl/ahb_dma_write_master.sv
// AHB-Lite INCR write master for the DMA path: writes N incrementing words from a base
// address, restarting the burst with NONSEQ at every KB_BOUNDARY crossing.
module ahb_dma_write_master #(
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned KB_BOUNDARY = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [5:0]  RCC_Words_N,
  input  logic [15:0] RCC_DMA_ADDR_HIGH,
  input  logic [15:0] RCC_DMA_ADDR_LOW,
  input  logic [31:0] init_data,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned BND_W = $clog2(KB_BOUNDARY);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] init_q, init_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        data_phase_s;
  logic        err_first_s;
  logic        err_now_s;
  logic        last_beat_s;
  logic [31:0] next_addr_s;
  logic        bnd_s;

  // idx_q is the beat in its address phase, so a data phase is live once idx_q has moved past 0
  assign data_phase_s = ((state_q == S_ADDR) && (idx_q != 6'd0)) || (state_q == S_LAST);
  assign err_first_s  = data_phase_s && HRESP && !HREADY;
  assign err_now_s    = data_phase_s && HRESP && HREADY;
  assign last_beat_s  = (idx_q == (n_q - 6'd1));
  assign next_addr_s  = haddr_q + 32'(ADDR_STEP);
  assign bnd_s        = (next_addr_s[BND_W-1:0] == {BND_W{1'b0}});

  // The first ERROR cycle must cancel the pending address phase in the same cycle
  assign HTRANS = err_first_s ? HT_IDLE : htrans_q;
  assign HWRITE = hwrite_q & ~err_first_s;
  assign HADDR  = haddr_q;
  assign HWDATA = hwdata_q;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b001;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && (RCC_Words_N != 6'd0)) state_d = S_ADDR;
        else                                state_d = S_IDLE;
      end
      S_ADDR: begin
        if (err_first_s)                 state_d = S_ERR;
        else if (err_now_s)              state_d = S_IDLE;
        else if (HREADY && last_beat_s)  state_d = S_LAST;
        else                             state_d = S_ADDR;
      end
      S_LAST: begin
        if (err_first_s)                state_d = S_ERR;
        else if (err_now_s || HREADY)   state_d = S_IDLE;
        else                            state_d = S_LAST;
      end
      S_ERR: begin
        if (HREADY) state_d = S_IDLE;
        else        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    idx_d    = idx_q;
    n_d      = n_q;
    init_d   = init_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          n_d     = RCC_Words_N;
          init_d  = init_data;
          idx_d   = 6'd0;
          if (RCC_Words_N != 6'd0) begin
            busy_d   = 1'b1;
            htrans_d = HT_NONSEQ;
            haddr_d  = {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW};
            hwrite_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_ADDR: begin
        if (err_first_s) begin
          htrans_d = HT_IDLE;
          hwrite_d = 1'b0;
        end else if (err_now_s) begin
          htrans_d = HT_IDLE;
          hwrite_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          error_d  = 1'b1;
        end else if (HREADY) begin
          hwdata_d = init_q + {26'd0, idx_q};
          if (last_beat_s) begin
            htrans_d = HT_IDLE;
            hwrite_d = 1'b0;
          end else begin
            idx_d    = idx_q + 6'd1;
            haddr_d  = next_addr_s;
            htrans_d = bnd_s ? HT_NONSEQ : HT_SEQ;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_LAST: begin
        if (err_first_s) begin
          htrans_d = HT_IDLE;
        end else if (err_now_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (HREADY) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        htrans_d = HT_IDLE;
        hwrite_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Datapath and registered bus outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_q    <= 6'd0;
      n_q      <= 6'd0;
      init_q   <= 32'd0;
      htrans_q <= HT_IDLE;
      haddr_q  <= 32'd0;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      n_q      <= n_d;
      init_q   <= init_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

endmodule
